trap_filter_cfg: RTL and testbench

Runtime-configurable trapezoidal pulse-shaping filter for one ADC channel, the next generation of our fixed-coefficient shaper. Delay lengths K and L, pole-zero factor M and output shift are programmed at run time within build-time maxima. Samples carry a valid/ready handshake. Output is saturated and qualified by a settle state machine. The block sits between the ADC capture stage and the peak/energy logic.

---
 rtl/package_settings.sv | 5 +
 rtl/trap_filter_pkg.sv | 14 +
 rtl/trap_delay_line.sv | 33 +++
 rtl/trap_filter_cfg.sv | 171 +++++++++++++++++
 tb/tb_trap_filter_cfg.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/package_settings.sv
// Project-wide data widths shared by the ADC front end and the shaping filters.
package package_settings;
    localparam int SIZE_ADC_DATA    = 14;
    localparam int SIZE_FILTER_DATA = 16;
endpackage

// File: rtl/trap_filter_pkg.sv
// Shared types, reset-time configuration and write legality check for trap_filter_cfg.
package trap_filter_pkg;
    typedef enum logic [1:0] {FLUSH, FILL, RUN} state_e;

    localparam int DEF_K  = 5;
    localparam int DEF_L  = 5;
    localparam int DEF_M  = 16;
    localparam int DEF_SH = 4;

    function automatic logic cfg_legal(input int k, input int l, input int sh,
                                       input int kmax, input int lmax, input int acc_w);
        return (k >= 1) && (k <= l) && (l <= lmax) && (k <= kmax) && (sh < acc_w);
    endfunction
endpackage

// File: rtl/trap_delay_line.sv
// Sample history for the trapezoid difference: shift register with clear and
// run-time selected taps at K, L and K+L samples back.
module trap_delay_line #(
    parameter int DEPTH = 48,
    parameter int DW    = 14,
    parameter int IW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          clr_i,
    input  logic          shift_i,
    input  logic [DW-1:0] din_i,
    input  logic [IW-1:0] k_i,
    input  logic [IW-1:0] l_i,
    output logic [DW-1:0] tap0_o,
    output logic [DW-1:0] tapk_o,
    output logic [DW-1:0] tapl_o,
    output logic [DW-1:0] tapkl_o
);
    // Entry 0 is the newest sample x[n]; entry i holds x[n-i].
    logic [DEPTH:0][DW-1:0] line_q;
    logic [IW-1:0]          kl;

    always_ff @(posedge clk) begin
        if (clr_i)        line_q <= '0;
        else if (shift_i) line_q <= {line_q[DEPTH-1:0], din_i};
    end

    assign kl      = k_i + l_i;
    assign tap0_o  = line_q[0];
    assign tapk_o  = line_q[k_i];
    assign tapl_o  = line_q[l_i];
    assign tapkl_o = line_q[kl];
endmodule

// File: rtl/trap_filter_cfg.sv
// Runtime-configurable trapezoidal shaper: delay-line difference, pole-zero
// correction, double accumulation, shift and saturating clip, with settle FSM.
module trap_filter_cfg
    import package_settings::*;
    import trap_filter_pkg::*;
#(
    parameter int KMAX   = 16,
    parameter int LMAX   = 32,
    parameter int MW     = 10,
    parameter int SHW    = 6,
    parameter int ACC_W  = 48,
    parameter int K_DEF  = DEF_K,
    parameter int L_DEF  = DEF_L,
    parameter int M_DEF  = DEF_M,
    parameter int SH_DEF = DEF_SH
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [SIZE_ADC_DATA-1:0]           input_data,
    input  logic                               cfg_we,
    input  logic [$clog2(KMAX+1)-1:0]          cfg_k,
    input  logic [$clog2(LMAX+1)-1:0]          cfg_l,
    input  logic [MW-1:0]                      cfg_m,
    input  logic [SHW-1:0]                     cfg_shift,
    output logic                               cfg_err,
    output logic                               out_valid,
    output logic signed [SIZE_FILTER_DATA-1:0] output_data,
    output logic                               out_sat
);
    localparam int KW     = $clog2(KMAX + 1);
    localparam int LW     = $clog2(LMAX + 1);
    localparam int AW     = SIZE_ADC_DATA;
    localparam int FW     = SIZE_FILTER_DATA;
    localparam int DEPTH  = KMAX + LMAX;
    localparam int IW     = $clog2(DEPTH + 1);
    localparam int STAGES = 5;
    localparam logic signed [ACC_W-1:0] OMAX = {{(ACC_W-FW+1){1'b0}}, {(FW-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] OMIN = {{(ACC_W-FW+1){1'b1}}, {(FW-1){1'b0}}};

    state_e          state_q;
    logic [KW-1:0]   k_q;
    logic [LW-1:0]   l_q;
    logic [MW-1:0]   m_q;
    logic [SHW-1:0]  sh_q;
    logic [IW-1:0]   fill_q, kl_sum;
    logic            in_ready_q, cfg_err_q;
    logic            accept, legal, restart, clr;

    assign accept  = in_valid && in_ready_q && !cfg_we;
    assign legal   = cfg_legal(int'(cfg_k), int'(cfg_l), int'(cfg_shift), KMAX, LMAX, ACC_W);
    assign restart = cfg_we && legal;
    assign kl_sum  = IW'(k_q) + IW'(l_q);
    // A legal write drops in-flight work immediately; FLUSH then clears once more.
    assign clr     = !reset || restart || (state_q == FLUSH);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= FILL;
            k_q        <= KW'(K_DEF);
            l_q        <= LW'(L_DEF);
            m_q        <= MW'(M_DEF);
            sh_q       <= SHW'(SH_DEF);
            fill_q     <= '0;
            in_ready_q <= 1'b0;
            cfg_err_q  <= 1'b0;
        end else begin
            cfg_err_q  <= cfg_we && !legal;
            in_ready_q <= !restart;
            if (restart) begin
                k_q     <= cfg_k;
                l_q     <= cfg_l;
                m_q     <= cfg_m;
                sh_q    <= cfg_shift;
                fill_q  <= '0;
                state_q <= FLUSH;
            end else begin
                case (state_q)
                    FLUSH: begin
                        fill_q  <= '0;
                        state_q <= FILL;
                    end
                    FILL: if (accept) begin
                        fill_q <= fill_q + IW'(1);
                        if (fill_q == kl_sum - IW'(1)) state_q <= RUN;
                    end
                    RUN: ;
                    default: state_q <= FILL;
                endcase
            end
        end
    end

    logic [AW-1:0] tap0, tapk, tapl, tapkl;

    trap_delay_line #(.DEPTH(DEPTH), .DW(AW), .IW(IW)) u_dly (
        .clk     (clk),
        .clr_i   (clr),
        .shift_i (accept),
        .din_i   (input_data),
        .k_i     (IW'(k_q)),
        .l_i     (IW'(l_q)),
        .tap0_o  (tap0),
        .tapk_o  (tapk),
        .tapl_o  (tapl),
        .tapkl_o (tapkl)
    );

    logic signed [ACC_W-1:0] x0, xk, xl, xkl, d2_d, m_ext, shifted;
    logic signed [ACC_W-1:0] d2_q, p_q, md2_q, r_q, s_q;
    logic signed [FW-1:0]    sat_val, out_data_q;
    logic                    sat_flag, out_sat_q;
    logic [STAGES-1:0]       vld_pipe;
    logic [STAGES:0]         qual_pipe;

    assign x0    = signed'(ACC_W'(tap0));
    assign xk    = signed'(ACC_W'(tapk));
    assign xl    = signed'(ACC_W'(tapl));
    assign xkl   = signed'(ACC_W'(tapkl));
    assign d2_d  = (x0 - xk) - (xl - xkl);
    assign m_ext = signed'(ACC_W'(m_q));

    always_comb begin
        shifted  = s_q >>> sh_q;
        sat_val  = shifted[FW-1:0];
        sat_flag = 1'b0;
        if (shifted > OMAX) begin
            sat_val  = OMAX[FW-1:0];
            sat_flag = 1'b1;
        end else if (shifted < OMIN) begin
            sat_val  = OMIN[FW-1:0];
            sat_flag = 1'b1;
        end
    end

    // vld_pipe[i] marks stage S(i+1) loading; qual_pipe additionally requires RUN.
    always_ff @(posedge clk) begin
        if (clr) begin
            vld_pipe   <= '0;
            qual_pipe  <= '0;
            d2_q       <= '0;
            p_q        <= '0;
            md2_q      <= '0;
            r_q        <= '0;
            s_q        <= '0;
            out_data_q <= '0;
            out_sat_q  <= 1'b0;
        end else begin
            vld_pipe  <= {vld_pipe[STAGES-2:0], accept};
            qual_pipe <= {qual_pipe[STAGES-1:0], accept && (state_q == RUN)};
            if (vld_pipe[0]) d2_q <= d2_d;
            if (vld_pipe[1]) begin
                p_q   <= p_q + d2_q;
                md2_q <= d2_q * m_ext;
            end
            if (vld_pipe[2]) r_q <= p_q + md2_q;
            if (vld_pipe[3]) s_q <= s_q + r_q;
            if (vld_pipe[4]) begin
                out_data_q <= sat_val;
                out_sat_q  <= sat_flag;
            end
        end
    end

    assign in_ready    = in_ready_q;
    assign cfg_err     = cfg_err_q;
    assign out_valid   = qual_pipe[STAGES];
    assign output_data = out_data_q;
    assign out_sat     = out_sat_q;
endmodule

// File: tb/tb_trap_filter_cfg.sv
// Directed bench for trap_filter_cfg: step, impulse, saturation, config reject/restart, reset.
module tb_trap_filter_cfg;
    import package_settings::*;

    localparam int KMAX = 16;
    localparam int LMAX = 32;
    localparam int MW   = 10;
    localparam int SHW  = 6;
    localparam int KW   = $clog2(KMAX + 1);
    localparam int LW   = $clog2(LMAX + 1);
    localparam int AW   = SIZE_ADC_DATA;
    localparam int FW   = SIZE_FILTER_DATA;

    logic                 clk, reset, in_valid, in_ready, cfg_we, cfg_err;
    logic                 out_valid, out_sat;
    logic [AW-1:0]        input_data;
    logic [KW-1:0]        cfg_k;
    logic [LW-1:0]        cfg_l;
    logic [MW-1:0]        cfg_m;
    logic [SHW-1:0]       cfg_shift;
    logic signed [FW-1:0] output_data;

    int n_assert = 0;
    int n_fail   = 0;
    logic signed [31:0] qv[$];
    logic               qs[$];

    trap_filter_cfg dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .input_data(input_data), .cfg_we(cfg_we), .cfg_k(cfg_k), .cfg_l(cfg_l),
        .cfg_m(cfg_m), .cfg_shift(cfg_shift), .cfg_err(cfg_err),
        .out_valid(out_valid), .output_data(output_data), .out_sat(out_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (out_valid) begin
        qv.push_back(32'(output_data));
        qs.push_back(out_sat);
    end

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_q(input string tag, input int idx, input int ev, input int es);
        n_assert++;
        assert (idx < qv.size()) else begin
            n_fail++;
            $error("FAIL %s: observed %0d outputs expected index %0d present", tag, qv.size(), idx);
        end
        if (idx < qv.size()) begin
            chk($sformatf("%s[%0d]", tag, idx), qv[idx], ev);
            chk($sformatf("%s_sat[%0d]", tag, idx), 32'(qs[idx]), es);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int x);
        in_valid   = 1'b1;
        input_data = AW'(x);
        tick();
        in_valid   = 1'b0;
    endtask

    task automatic send_n(input int x, input int n);
        repeat (n) send(x);
    endtask

    task automatic cfg_write(input int k, input int l, input int m, input int sh,
                             input bit offer, input int x, output bit err1, output bit rdy1);
        cfg_we     = 1'b1;
        cfg_k      = KW'(k);
        cfg_l      = LW'(l);
        cfg_m      = MW'(m);
        cfg_shift  = SHW'(sh);
        in_valid   = offer;
        input_data = AW'(x);
        tick();
        err1     = cfg_err;
        rdy1     = in_ready;
        cfg_we   = 1'b0;
        in_valid = 1'b0;
    endtask

    initial begin
        bit err, rdy;
        int cnt;
        int smax, smin, full;
        int exp_step[18] = '{0, 0, 0, 0, 106, 218, 231, 243, 150, 50, 50, 50, 50, 50, 50, 50, 50, 50};
        int exp_imp[9]   = '{0, 0, 16, 16, 0, 0, 0, 0, 0};
        int exp_rej[8]   = '{0, 0, 16, 16, 0, 0, 0, 0};
        int exp_rst[8]   = '{106, 218, 231, 243, 150, 50, 50, 50};
        int exp_def[12]  = '{106, 218, 337, 462, 593, 518, 437, 350, 256, 156, 156, 156};
        smax = (1 << (FW - 1)) - 1;
        smin = -(1 << (FW - 1));
        full = (1 << AW) - 1;

        reset = 1'b0; in_valid = 1'b0; input_data = '0; cfg_we = 1'b0;
        cfg_k = '0; cfg_l = '0; cfg_m = '0; cfg_shift = '0;
        tick();
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_output_data", 32'(output_data), 0);
        chk("rst_out_sat", 32'(out_sat), 0);
        chk("rst_cfg_err", 32'(cfg_err), 0);
        tick();
        reset = 1'b1;
        tick();
        chk("rel_in_ready", 32'(in_ready), 1);

        // Step response K=2 L=4 M=16 SHIFT=4
        cfg_write(2, 4, 16, 4, 1'b0, 0, err, rdy);
        chk("step_cfg_err", 32'(err), 0);
        chk("step_flush_ready", 32'(rdy), 0);
        tick();
        chk("step_fill_ready", 32'(in_ready), 1);
        qv.delete(); qs.delete();
        send_n(0, 10);
        send_n(100, 14);
        repeat (8) tick();
        chk("step_count", qv.size(), 18);
        for (int i = 0; i < 18; i++) chk_q("step", i, exp_step[i], 0);

        // Impulse K=1 L=2 M=0 SHIFT=0
        cfg_write(1, 2, 0, 0, 1'b0, 0, err, rdy);
        tick();
        qv.delete(); qs.delete();
        send_n(0, 5);
        send(16);
        send_n(0, 6);
        repeat (8) tick();
        chk("imp_count", qv.size(), 9);
        for (int i = 0; i < 9; i++) chk_q("imp", i, exp_imp[i], 0);

        // Accept-to-out_valid latency and single-sample gap behaviour
        in_valid = 1'b1; input_data = '0;
        tick();
        in_valid = 1'b0;
        cnt = 0;
        while (!out_valid && cnt < 20) begin
            tick();
            cnt++;
        end
        chk("latency", cnt, 5);
        tick();
        chk("gap_out_valid", 32'(out_valid), 0);

        // Illegal write in RUN: stream continues with the old configuration
        qv.delete(); qs.delete();
        send_n(0, 2);
        cfg_write(6, 3, 0, 0, 1'b0, 0, err, rdy);
        chk("rej_cfg_err", 32'(err), 1);
        chk("rej_in_ready", 32'(rdy), 1);
        tick();
        chk("rej_err_pulse", 32'(cfg_err), 0);
        send(16);
        send_n(0, 5);
        repeat (8) tick();
        chk("rej_count", qv.size(), 8);
        for (int i = 0; i < 8; i++) chk_q("rej", i, exp_rej[i], 0);

        // Legal write in RUN with an in-flight sample and a sample offered alongside
        qv.delete(); qs.delete();
        send(16);
        cfg_write(2, 4, 16, 4, 1'b1, 100, err, rdy);
        chk("rst_cfg_err0", 32'(err), 0);
        chk("rst_flush_ready", 32'(rdy), 0);
        tick();
        chk("rst_fill_ready", 32'(in_ready), 1);
        send_n(0, 6);
        send_n(100, 8);
        repeat (8) tick();
        chk("restart_count", qv.size(), 8);
        for (int i = 0; i < 8; i++) chk_q("restart", i, exp_rst[i], 0);

        // Saturation K=16 L=32 M=1023 SHIFT=0
        cfg_write(16, 32, 1023, 0, 1'b0, 0, err, rdy);
        chk("sat_cfg_err", 32'(err), 0);
        tick();
        qv.delete(); qs.delete();
        send_n(0, 50);
        send_n(full, 60);
        send_n(0, 60);
        repeat (8) tick();
        chk("sat_count", qv.size(), 122);
        chk_q("sat_pre", 0, 0, 0);
        chk_q("sat_rise", 2, smax, 1);
        chk_q("sat_high", 61, smax, 1);
        chk_q("sat_fall", 62, smin, 1);
        chk_q("sat_end", 121, 0, 0);

        // Reset mid-stream, then default configuration 5/5/16/4 from FILL
        send_n(full, 10);
        chk("pre_rst_valid", 32'(out_valid), 1);
        chk("pre_rst_data", 32'(output_data), smax);
        in_valid = 1'b1; input_data = AW'(full);
        reset = 1'b0;
        tick();
        chk("mid_rst_valid", 32'(out_valid), 0);
        chk("mid_rst_data", 32'(output_data), 0);
        chk("mid_rst_sat", 32'(out_sat), 0);
        chk("mid_rst_ready", 32'(in_ready), 0);
        chk("mid_rst_err", 32'(cfg_err), 0);
        reset = 1'b1; in_valid = 1'b0;
        tick();
        chk("mid_rel_ready", 32'(in_ready), 1);
        qv.delete(); qs.delete();
        send_n(0, 10);
        send_n(100, 12);
        repeat (8) tick();
        chk("def_count", qv.size(), 12);
        for (int i = 0; i < 12; i++) chk_q("def", i, exp_def[i], 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
